// File: rtl/hdmi_cfg_seq_pkg.sv
// Shared types, entry encoding helpers and the default board register table
// for the HDMI transmitter configuration sequencer.
package hdmi_cfg_seq_pkg;

  localparam int ENTRY_W     = 17;
  localparam int DEF_ENTRIES = 64;

  // Any entry matching this mask (kind=1, hi=8'hFF) terminates the table.
  localparam logic [ENTRY_W-1:0] END_MASK = 17'h1FF00;

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [31:0]        cnt_t;

  typedef enum logic {
    KIND_WR  = 1'b0,
    KIND_DLY = 1'b1
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [7:0] hi;
    logic [7:0] lo;
  } entry_s;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic entry_t mk_wr(input logic [7:0] reg_addr, input logic [7:0] data);
    return {1'b0, reg_addr, data};
  endfunction

  function automatic entry_t mk_dly(input logic [7:0] units);
    return {1'b1, 8'h00, units};
  endfunction

  function automatic entry_t mk_end();
    return END_MASK;
  endfunction

  function automatic logic is_end(input entry_t e);
    return (e & END_MASK) == END_MASK;
  endfunction

  // Board bring-up table for the HDMI transmitter; the only per-board change.
  function automatic entry_t board_entry(input int idx);
    entry_t e;
    e = mk_end();
    case (idx)
      0:  e = mk_wr(8'h41, 8'h10);
      1:  e = mk_dly(8'd20);
      2:  e = mk_wr(8'h98, 8'h03);
      3:  e = mk_wr(8'h9A, 8'hE0);
      4:  e = mk_wr(8'h9C, 8'h30);
      5:  e = mk_wr(8'h9D, 8'h61);
      6:  e = mk_wr(8'hA2, 8'hA4);
      7:  e = mk_wr(8'hA3, 8'hA4);
      8:  e = mk_wr(8'hE0, 8'hD0);
      9:  e = mk_wr(8'hF9, 8'h00);
      10: e = mk_wr(8'h15, 8'h00);
      11: e = mk_wr(8'h16, 8'h30);
      12: e = mk_wr(8'h17, 8'h02);
      13: e = mk_wr(8'h18, 8'h46);
      14: e = mk_wr(8'hAF, 8'h06);
      default: e = mk_end();
    endcase
    return e;
  endfunction

  function automatic logic [DEF_ENTRIES*ENTRY_W-1:0] build_table();
    logic [DEF_ENTRIES*ENTRY_W-1:0] t;
    t = '0;
    for (int i = 0; i < DEF_ENTRIES; i++) t[i*ENTRY_W +: ENTRY_W] = board_entry(i);
    return t;
  endfunction

  localparam logic [DEF_ENTRIES*ENTRY_W-1:0] DEFAULT_TABLE = build_table();

endpackage

// File: rtl/hdmi_cfg_seq_rom.sv
// Registered lookup of the configuration table: one cycle from index to entry.
module hdmi_cfg_seq_rom
  import hdmi_cfg_seq_pkg::*;
#(
  parameter int                               NUM_ENTRIES = DEF_ENTRIES,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0]   TABLE       = DEFAULT_TABLE,
  localparam int                              IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] index,
  output entry_t           entry
);

  entry_t entry_d, entry_q;

  always_comb entry_d = TABLE[int'(index)*ENTRY_W +: ENTRY_W];

  // NOTE: the table is a constant, so only the output register needs a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entry = entry_q;

endmodule

// File: rtl/hdmi_cfg_seq.sv
// Walks the register table and hands each write to the I2C core as one
// request/done handshake, with inline delays, timeout and restart on start.
module hdmi_cfg_seq
  import hdmi_cfg_seq_pkg::*;
#(
  parameter logic [6:0]                     DEV_ADDR     = 7'h39,
  parameter int                             NUM_ENTRIES  = 64,
  parameter int                             POWERUP_WAIT = 20000,
  parameter int                             RQT_HOLD     = 4,
  parameter int                             GAP_CYCLES   = 500,
  parameter int                             DELAY_UNIT   = 10000,
  parameter int                             TIMEOUT      = 65535,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0] ROM_TABLE    = DEFAULT_TABLE,
  localparam int                            IDX_W        = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             i2c_done,
  output logic             i2c_rqt,
  output logic             cmd,
  output logic [6:0]       addr_dev,
  output logic [7:0]       addr_reg_H,
  output logic [7:0]       addr_reg_L,
  output logic [7:0]       data_wr_H,
  output logic [7:0]       data_wr_L,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_index
);

  state_e           state_d, state_q;
  cnt_t             cnt_d, cnt_q;
  logic [IDX_W-1:0] index_d, index_q;
  logic [IDX_W-1:0] err_idx_d, err_idx_q;
  logic [7:0]       reg_d, reg_q, data_d, data_q;
  logic             rqt_d, rqt_q, done_d, done_q, err_d, err_q;
  logic             sync_q, sync_prev_q, done_rise;
  entry_t           rom_entry;
  entry_s           ent;

  hdmi_cfg_seq_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .TABLE       (ROM_TABLE)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index_q),
    .entry (rom_entry)
  );

  assign ent       = rom_entry;
  assign done_rise = sync_q & ~sync_prev_q;

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    index_d   = index_q;
    err_idx_d = err_idx_q;
    reg_d     = reg_q;
    data_d    = data_q;
    rqt_d     = rqt_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == '0) state_d = ST_FETCH;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (ent.kind == KIND_WR) begin
          reg_d   = ent.hi;
          data_d  = ent.lo;
          rqt_d   = 1'b1;
          cnt_d   = cnt_t'(RQT_HOLD - 1);
          state_d = ST_ISSUE;
        end else if (is_end(rom_entry)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (ent.lo == 8'h00) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d   = cnt_t'(ent.lo) * cnt_t'(DELAY_UNIT) - cnt_t'(1);
          state_d = ST_DELAY;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          rqt_d   = 1'b0;
          cnt_d   = cnt_t'(TIMEOUT);
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (done_rise) begin
          cnt_d   = cnt_t'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else if (cnt_q == '0) begin
          err_d     = 1'b1;
          err_idx_d = index_q;
          state_d   = ST_ERROR;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_GAP, ST_DELAY: begin
        if (cnt_q == '0) state_d = ST_NEXT;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      ST_NEXT: begin
        if (index_q == IDX_W'(NUM_ENTRIES - 1)) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
          index_d   = '0;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= cnt_t'(POWERUP_WAIT - 1);
      index_q     <= '0;
      err_idx_q   <= '0;
      reg_q       <= '0;
      data_q      <= '0;
      rqt_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      err_idx_q   <= err_idx_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      rqt_q       <= rqt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sync_q      <= i2c_done;
      sync_prev_q <= sync_q;
    end
  end

  assign i2c_rqt    = rqt_q;
  assign cmd        = 1'b1;
  assign addr_dev   = DEV_ADDR;
  assign addr_reg_H = reg_q;
  assign addr_reg_L = 8'h00;
  assign data_wr_H  = data_q;
  assign data_wr_L  = 8'h00;
  assign cfg_busy   = !(state_q inside {ST_PWR_WAIT, ST_DONE, ST_ERROR});
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign err_index  = err_idx_q;

endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Scoreboard bench: instance A runs a short table with a delay entry, instance B
// a full 64-write table without END; behavioural I2C core models answer requests.
module tb_hdmi_cfg_seq;
  import hdmi_cfg_seq_pkg::*;

  localparam int PW  = 40;
  localparam int HLD = 4;
  localparam int GAP = 80;
  localparam int DU  = 16;
  localparam int TO  = 300;
  localparam int LAT = 10;
  localparam int DHI = 50;

  function automatic logic [64*ENTRY_W-1:0] table_a();
    logic [64*ENTRY_W-1:0] t;
    t = '0;
    t[0*ENTRY_W +: ENTRY_W] = mk_wr(8'h08, 8'h35);
    t[1*ENTRY_W +: ENTRY_W] = mk_dly(8'd3);
    t[2*ENTRY_W +: ENTRY_W] = mk_wr(8'h41, 8'h10);
    t[3*ENTRY_W +: ENTRY_W] = mk_dly(8'd0);
    t[4*ENTRY_W +: ENTRY_W] = mk_wr(8'h1A, 8'h00);
    t[5*ENTRY_W +: ENTRY_W] = mk_end();
    return t;
  endfunction

  function automatic logic [15:0] b_tx(input int i);
    return {8'(i), 8'(i * 7 + 3)};
  endfunction

  function automatic logic [64*ENTRY_W-1:0] table_b();
    logic [64*ENTRY_W-1:0] t;
    logic [15:0] tx;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      tx = b_tx(i);
      t[i*ENTRY_W +: ENTRY_W] = mk_wr(tx[15:8], tx[7:0]);
    end
    return t;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n_a, rst_n_b, start_a, start_b, done_a, done_b;
  logic       rqt_a, cmd_a, busy_a, cdone_a, cerr_a;
  logic       rqt_b, cmd_b, busy_b, cdone_b, cerr_b;
  logic [6:0] dev_a, dev_b;
  logic [7:0] rh_a, rl_a, dh_a, dl_a, rh_b, rl_b, dh_b, dl_b;
  logic [5:0] eidx_a, eidx_b;

  hdmi_cfg_seq #(
    .DEV_ADDR(7'h39), .NUM_ENTRIES(64), .POWERUP_WAIT(PW), .RQT_HOLD(HLD),
    .GAP_CYCLES(GAP), .DELAY_UNIT(DU), .TIMEOUT(TO), .ROM_TABLE(table_a())
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .i2c_done(done_a), .i2c_rqt(rqt_a),
    .cmd(cmd_a), .addr_dev(dev_a), .addr_reg_H(rh_a), .addr_reg_L(rl_a),
    .data_wr_H(dh_a), .data_wr_L(dl_a), .cfg_busy(busy_a), .cfg_done(cdone_a),
    .cfg_err(cerr_a), .err_index(eidx_a)
  );

  hdmi_cfg_seq #(
    .DEV_ADDR(7'h39), .NUM_ENTRIES(64), .POWERUP_WAIT(PW), .RQT_HOLD(HLD),
    .GAP_CYCLES(GAP), .DELAY_UNIT(DU), .TIMEOUT(TO), .ROM_TABLE(table_b())
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .i2c_done(done_b), .i2c_rqt(rqt_b),
    .cmd(cmd_b), .addr_dev(dev_b), .addr_reg_H(rh_b), .addr_reg_L(rl_b),
    .data_wr_H(dh_b), .data_wr_L(dl_b), .cfg_busy(busy_b), .cfg_done(cdone_b),
    .cfg_err(cerr_b), .err_index(eidx_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int          rqt_cyc_a[$];
  int          done_cyc_a[$];
  int          rqt_fall_cyc_a = 0;
  int          rqt_edges_b    = 0;
  logic        suppress_a     = 1'b0;

  // Core model A: done rises LAT cycles after a request edge and stays DHI cycles.
  initial begin : model_a
    logic prev;
    prev   = 1'b0;
    done_a = 1'b0;
    forever begin
      @(negedge clk);
      if (rqt_a && !prev && !(suppress_a && rh_a == 8'h41)) begin
        repeat (LAT) @(negedge clk);
        done_a = 1'b1;
        done_cyc_a.push_back(cyc);
        repeat (DHI) @(negedge clk);
        done_a = 1'b0;
      end
      prev = rqt_a;
    end
  end

  // Core model B: same timing plus a one-cycle done glitch inside the gap of entry 5.
  initial begin : model_b
    logic prev;
    int   n;
    prev   = 1'b0;
    n      = 0;
    done_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rqt_b && !prev) begin
        repeat (LAT) @(negedge clk);
        done_b = 1'b1;
        repeat (DHI) @(negedge clk);
        done_b = 1'b0;
        if (n == 5) begin
          repeat (10) @(negedge clk);
          done_b = 1'b1;
          @(negedge clk);
          done_b = 1'b0;
        end
        n++;
      end
      prev = rqt_b;
    end
  end

  // Monitor A: each request edge pops the next expected write.
  initial begin : mon_a
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rqt_a && !prev) begin
        rqt_cyc_a.push_back(cyc);
        check("a_rqt_expected", 64'(exp_a.size() != 0), 64'(1));
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check("a_tx", 64'({cmd_a, dev_a, rh_a, rl_a, dh_a, dl_a}),
                64'({1'b1, 7'h39, e[15:8], 8'h00, e[7:0], 8'h00}));
        end
      end
      if (!rqt_a && prev) rqt_fall_cyc_a = cyc;
      prev = rqt_a;
    end
  end

  initial begin : mon_b
    logic prev;
    logic [15:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rqt_b && !prev) begin
        rqt_edges_b++;
        check("b_rqt_expected", 64'(exp_b.size() != 0), 64'(1));
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check("b_tx", 64'({cmd_b, dev_b, rh_b, rl_b, dh_b, dl_b}),
                64'({1'b1, 7'h39, e[15:8], 8'h00, e[7:0], 8'h00}));
        end
      end
      prev = rqt_b;
    end
  end

  task automatic push_full_a();
    exp_a.push_back(16'h0835);
    exp_a.push_back(16'h4110);
    exp_a.push_back(16'h1A00);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_end_a(input string name, input int budget);
    int n = 0;
    while (!(cdone_a || cerr_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(cdone_a | cerr_a), 64'(1));
  endtask

  task automatic wait_rqt_a(input string name, input int budget);
    int n = 0;
    while (!rqt_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(rqt_a), 64'(1));
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rel, gap, err_cyc;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    push_full_a();
    for (int i = 0; i < 64; i++) exp_b.push_back(b_tx(i));
    repeat (5) @(negedge clk);
    check("a_reset_state",
          64'({rqt_a, cmd_a, dev_a, rh_a, rl_a, dh_a, dl_a, busy_a, cdone_a, cerr_a, eidx_a}),
          64'({1'b0, 1'b1, 7'h39, 32'h0, 3'b000, 6'd0}));
    check("b_reset_state",
          64'({rqt_b, cmd_b, dev_b, rh_b, rl_b, dh_b, dl_b, busy_b, cdone_b, cerr_b, eidx_b}),
          64'({1'b0, 1'b1, 7'h39, 32'h0, 3'b000, 6'd0}));

    // Run 1: power-up wait, two writes around a 3-unit delay, END.
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    rel = cyc;
    repeat (5) @(negedge clk);
    check("a_busy_in_pwr_wait", 64'(busy_a), 64'(0));
    wait_end_a("a_run1_finish", 3000);
    check("a_run1_flags", 64'({cdone_a, cerr_a, busy_a, rqt_a}), 64'(4'b1000));
    check("a_run1_queue_empty", 64'(exp_a.size()), 64'(0));
    check("a_powerup_min", 64'((rqt_cyc_a[0] - rel) >= PW), 64'(1));
    check("a_powerup_max", 64'((rqt_cyc_a[0] - rel) <= PW + 10), 64'(1));
    gap = rqt_cyc_a[1] - done_cyc_a[0];
    check("a_delay_gap_min", 64'(gap >= GAP + 3 * DU), 64'(1));
    check("a_delay_gap_max", 64'(gap <= GAP + 3 * DU + 20), 64'(1));

    // Run 2: start in DONE replays; a start pulse mid-run is ignored.
    push_full_a();
    pulse_start_a();
    check("a_restart_busy", 64'({busy_a, cdone_a}), 64'(2'b10));
    wait_rqt_a("a_run2_first_rqt", 200);
    repeat (20) @(negedge clk);
    pulse_start_a();
    wait_end_a("a_run2_finish", 3000);
    check("a_run2_flags", 64'({cdone_a, cerr_a, busy_a}), 64'(3'b100));
    check("a_run2_queue_empty", 64'(exp_a.size()), 64'(0));

    // Run 3: core never answers entry 2 -> timeout.
    suppress_a = 1'b1;
    exp_a.push_back(16'h0835);
    exp_a.push_back(16'h4110);
    pulse_start_a();
    wait_end_a("a_run3_finish", 3000);
    err_cyc = cyc;
    check("a_err_flags", 64'({cdone_a, cerr_a, busy_a, rqt_a}), 64'(4'b0100));
    check("a_err_index", 64'(eidx_a), 64'(2));
    check("a_timeout_cycles", 64'(err_cyc - rqt_fall_cyc_a), 64'(TO + 1));
    repeat (30) @(negedge clk);
    check("a_err_sticky", 64'({cerr_a, eidx_a, rqt_a}), 64'({1'b1, 6'd2, 1'b0}));
    check("a_run3_queue_empty", 64'(exp_a.size()), 64'(0));

    // Run 4: start from ERROR clears the error and replays everything.
    suppress_a = 1'b0;
    push_full_a();
    pulse_start_a();
    check("a_err_cleared", 64'({busy_a, cerr_a, cdone_a}), 64'(3'b100));
    wait_end_a("a_run4_finish", 3000);
    check("a_run4_flags", 64'({cdone_a, cerr_a, busy_a}), 64'(3'b100));
    check("a_run4_queue_empty", 64'(exp_a.size()), 64'(0));

    // Run 5: reset asserted while the request is high aborts at once.
    exp_a.push_back(16'h0835);
    pulse_start_a();
    wait_rqt_a("a_run5_rqt", 200);
    #2 rst_n_a = 1'b0;
    #1;
    check("a_async_reset",
          64'({rqt_a, busy_a, cdone_a, cerr_a, rh_a, dh_a}), 64'({4'b0000, 16'h0000}));
    repeat (100) @(negedge clk);
    check("a_run5_queue_empty_abort", 64'(exp_a.size()), 64'(0));
    push_full_a();
    rst_n_a = 1'b1;
    wait_end_a("a_run5_finish", 3000);
    check("a_run5_flags", 64'({cdone_a, cerr_a, busy_a}), 64'(3'b100));
    check("a_run5_queue_empty", 64'(exp_a.size()), 64'(0));

    // Instance B: 64 writes with no END marker, glitch on done ignored.
    begin
      int n = 0;
      while (!(cdone_b || cerr_b) && n < 12000) begin
        @(negedge clk);
        n++;
      end
    end
    check("b_finish", 64'({cdone_b, cerr_b, busy_b}), 64'(3'b100));
    check("b_rqt_edges", 64'(rqt_edges_b), 64'(64));
    check("b_queue_empty", 64'(exp_b.size()), 64'(0));
    repeat (20) @(negedge clk);
    check("b_no_extra_rqt", 64'({rqt_edges_b, rqt_b}), 64'({32'd64, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
